// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Decode-control and instruction-memory signals of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            stallD;
  logic [1:0]      pc_selD;
  logic [XLEN-1:0] branch_tgtD;
  logic [XLEN-1:0] jalr_tgtD;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] pc_plus4F;
  logic [XLEN-1:0] instrF;
  logic            validF;

  modport master (
    input  stallD, pc_selD, branch_tgtD, jalr_tgtD, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc_plus4F, instrF, validF
  );

  modport slave (
    output stallD, pc_selD, branch_tgtD, jalr_tgtD, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc_plus4F, instrF, validF
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding-request instruction fetch stage with stall
//            and branch/jalr redirect.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_2000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] c_PC_INC     = XLEN'(4);
  localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(3));

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_buf;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_valid;
  logic            w_capture;
  logic            w_advance;

  assign w_pc_plus4 = r_pc + c_PC_INC;
  assign w_valid    = (r_state == S_VALID);
  assign w_capture  = (r_state == S_WAIT) && bus.imem_rvalid;
  assign w_advance  = w_valid && !bus.stallD;

  // Selector 11 is reserved and falls back to sequential fetch.
  always_comb begin
    w_pc_nxt = w_pc_plus4;
    case (bus.pc_selD)
      2'b01:   w_pc_nxt = bus.branch_tgtD & c_ALIGN_MASK;
      2'b10:   w_pc_nxt = bus.jalr_tgtD & c_ALIGN_MASK;
      default: w_pc_nxt = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.imem_rvalid) w_state_nxt = S_VALID;
      S_VALID: if (!bus.stallD)     w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_buf <= bus.imem_rdata;
      if (w_advance) r_pc  <= w_pc_nxt;
    end
  end

  // Outputs depend only on state and registers, never on decode-side inputs.
  assign bus.imem_req  = (r_state == S_REQ);
  assign bus.imem_addr = r_pc;
  assign bus.validF    = w_valid;
  assign bus.instrF    = w_valid ? r_buf : NOP_INSTR;
  assign bus.pc_plus4F = w_valid ? w_pc_plus4 : '0;

endmodule
`default_nettype wire
